// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter that drives the shared 4:1 select and valid-gated output.
// Request-to-grant takes 1 cycle, handover has no bubble, y is combinational from the registered select, and there is no backpressure.
module rr_mux_arbiter #(
   parameter int WIDTH     = 1,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [3:0]       grant,
   output logic             s1,
   output logic             s0,
   output logic [WIDTH-1:0] y,
   output logic             valid
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   localparam logic [3:0] CNT_MAX = 4'(MAX_BURST - 1);

   state_t     state_q, state_d;
   logic [3:0] grant_q, grant_d;
   logic [1:0] sel_q,   sel_d;
   logic [1:0] ptr_q,   ptr_d;
   logic [3:0] cnt_q,   cnt_d;

   logic [3:0] owner_oh;
   logic [3:0] others;
   logic [3:0] search_mask;
   logic [1:0] search_start;
   logic [1:0] cand;
   logic       win_found;
   logic [1:0] win_idx;
   logic       release_own;

   always_comb begin
      owner_oh     = 4'b0001 << sel_q;
      others       = req & ~owner_oh;
      release_own  = !req[sel_q] || ((cnt_q == CNT_MAX) && (others != 4'b0000));
      search_start = (state_q == IDLE) ? ptr_q : (sel_q + 2'd1);
      search_mask  = (state_q == IDLE) ? req : others;

      // Walk offsets downwards so the nearest requester in search order wins last.
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         cand = search_start + 2'(i);
         if (search_mask[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = GRANT;
               grant_d = 4'b0001 << win_idx;
               sel_d   = win_idx;
               cnt_d   = 4'd0;
            end
         end
         GRANT: begin
            if (release_own) begin
               ptr_d = sel_q + 2'd1;
               cnt_d = 4'd0;
               if (win_found) begin
                  grant_d = 4'b0001 << win_idx;
                  sel_d   = win_idx;
               end else begin
                  state_d = IDLE;
                  grant_d = 4'b0000;
               end
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= 4'b0000;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant = grant_q;
   assign s1    = sel_q[1];
   assign s0    = sel_q[0];
   assign valid = |grant_q;

   always_comb begin
      y = '0;
      if (valid) begin
         case (sel_q)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: default burst of 4 plus a MAX_BURST=1 instance on the same inputs.
module tb_rr_mux_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [0:0] a, b, c, d;
   logic [3:0] grant, grant1;
   logic       s1, s0, s1_1, s0_1;
   logic [0:0] y, y1;
   logic       valid, valid1;

   int n_vec;
   int n_err;

   rr_mux_arbiter #(.WIDTH(1), .MAX_BURST(4)) u_dut (
      .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
      .grant(grant), .s1(s1), .s0(s0), .y(y), .valid(valid)
   );

   rr_mux_arbiter #(.WIDTH(1), .MAX_BURST(1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
      .grant(grant1), .s1(s1_1), .s0(s0_1), .y(y1), .valid(valid1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grant must never be more than one-hot on either instance.
   always @(negedge clk) begin
      if (!rst) begin
         n_vec++;
         assert ($onehot0(grant) && $onehot0(grant1))
         else begin
            n_err++;
            $display("FAIL onehot: grant=%b grant1=%b required one-hot or zero", grant, grant1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b0000;
      a = 1'b1; b = 1'b1; c = 1'b1; d = 1'b1;
      repeat (3) tick();
      n_vec++;
      if ({grant, s1, s0, valid, y} !== 8'b0) begin
         n_err++;
         $display("FAIL reset_held: got grant=%b sel=%b%b valid=%b y=%b, want all zero", grant, s1, s0, valid, y);
      end
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_vec++;
         if ({grant, s1, s0, valid, y} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_idle[%0d]: got grant=%b sel=%b%b valid=%b y=%b, want all zero", k, grant, s1, s0, valid, y);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      a = 1'b0; b = 1'b0; c = 1'b1; d = 1'b0;
      req = 4'b0100;
      tick();
      n_vec++;
      if ({grant, s1, s0, valid, y} !== 8'b0100_10_1_1) begin
         n_err++;
         $display("FAIL single_first: got grant=%b sel=%b%b valid=%b y=%b, want 0100 10 1 1", grant, s1, s0, valid, y);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         n_vec++;
         if (grant !== 4'b0100) begin
            n_err++;
            $display("FAIL single_hold[%0d]: got %b want 0100", k, grant);
         end
      end
      req = 4'b0000;
      tick();
      n_vec++;
      if ({grant, s1, s0, valid, y} !== 8'b0000_10_0_0) begin
         n_err++;
         $display("FAIL single_drop: got grant=%b sel=%b%b valid=%b y=%b, want 0000 10 0 0", grant, s1, s0, valid, y);
      end
   endtask

   task automatic test_round_robin();
      int owner;
      logic [3:0] exp_g;
      logic [0:0] exp_y;
      do_reset();
      a = 1'b0; b = 1'b1; c = 1'b0; d = 1'b1;
      req = 4'b1111;
      for (int k = 1; k <= 20; k++) begin
         tick();
         owner = ((k - 1) / 4) % 4;
         exp_g = 4'b0001 << owner;
         exp_y = owner[0];
         n_vec++;
         if (grant !== exp_g || y !== exp_y) begin
            n_err++;
            $display("FAIL rr_cycle[%0d]: got grant=%b y=%b want grant=%b y=%b", k, grant, y, exp_g, exp_y);
         end
      end
   endtask

   task automatic test_early_release();
      do_reset();
      a = 1'b1; b = 1'b0; c = 1'b0; d = 1'b0;
      req = 4'b0010;
      tick();
      req = 4'b0011;
      tick();
      n_vec++;
      if (grant !== 4'b0010) begin
         n_err++;
         $display("FAIL early_owner_b: got %b want 0010", grant);
      end
      req = 4'b0001;
      tick();
      n_vec++;
      if (grant !== 4'b0001 || valid !== 1'b1 || y !== 1'b1) begin
         n_err++;
         $display("FAIL early_handover: got grant=%b valid=%b y=%b want 0001 1 1", grant, valid, y);
      end
      req = 4'b0011;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++;
         if (grant !== 4'b0001) begin
            n_err++;
            $display("FAIL early_cnt_restart[%0d]: got %b want 0001", k, grant);
         end
      end
      tick();
      n_vec++;
      if (grant !== 4'b0010) begin
         n_err++;
         $display("FAIL early_burst_end: got %b want 0010", grant);
      end
      // b now drops while a and d request; search starts at c so d wins.
      req = 4'b1001;
      tick();
      n_vec++;
      if (grant !== 4'b1000 || {s1, s0} !== 2'b11) begin
         n_err++;
         $display("FAIL ptr_handover: got grant=%b sel=%b%b want 1000 11", grant, s1, s0);
      end
   endtask

   task automatic test_priority_ptr();
      do_reset();
      req = 4'b0010;
      tick();
      req = 4'b0000;
      tick();
      n_vec++;
      if (grant !== 4'b0000 || {s1, s0} !== 2'b01) begin
         n_err++;
         $display("FAIL ptr_idle: got grant=%b sel=%b%b want 0000 01", grant, s1, s0);
      end
      req = 4'b1001;
      tick();
      n_vec++;
      if (grant !== 4'b1000 || {s1, s0} !== 2'b11) begin
         n_err++;
         $display("FAIL ptr_from_idle: got grant=%b sel=%b%b want 1000 11", grant, s1, s0);
      end
   endtask

   task automatic test_drop_raise();
      do_reset();
      req = 4'b0001;
      tick();
      req = 4'b0100;
      tick();
      n_vec++;
      if (grant !== 4'b0100 || valid !== 1'b1) begin
         n_err++;
         $display("FAIL drop_raise: got grant=%b valid=%b want 0100 1", grant, valid);
      end
   endtask

   task automatic test_burst_one();
      logic [3:0] exp_g;
      do_reset();
      req = 4'b0101;
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp_g = (k % 2 == 1) ? 4'b0001 : 4'b0100;
         n_vec++;
         if (grant1 !== exp_g) begin
            n_err++;
            $display("FAIL burst1_rotate[%0d]: got %b want %b", k, grant1, exp_g);
         end
      end
      req = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++;
         if (grant1 !== 4'b0001) begin
            n_err++;
            $display("FAIL burst1_alone[%0d]: got %b want 0001", k, grant1);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      a = 1'b0; b = 1'b0; c = 1'b1; d = 1'b0;
      req = 4'b0010;
      tick();
      req = 4'b0100;
      tick();
      tick();
      n_vec++;
      if (grant !== 4'b0100) begin
         n_err++;
         $display("FAIL areset_setup: got %b want 0100", grant);
      end
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({grant, s1, s0, valid, y} !== 8'b0) begin
         n_err++;
         $display("FAIL areset_immediate: got grant=%b sel=%b%b valid=%b y=%b want all zero", grant, s1, s0, valid, y);
      end
      req = 4'b1111;
      #1;
      rst = 1'b0;
      tick();
      n_vec++;
      if (grant !== 4'b0001) begin
         n_err++;
         $display("FAIL areset_restart: got %b want 0001", grant);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      req = 4'b0000;
      a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_early_release();
      test_priority_ptr();
      test_drop_raise();
      test_burst_one();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Four-requester round-robin arbiter that shares one 4:1 selection datapath between sources a, b, c and d. It owns the s1/s0 select lines and gates the muxed output with a valid flag. Each owner keeps the grant for a bounded burst of cycles. The block sits directly in front of the shared output consumer. It replaces static, testbench-driven select sequencing with request-driven scheduling.

Parameters:
WIDTH, 1, bit width of each data input and of y.
MAX_BURST, 4, maximum consecutive grant cycles per owner while other requests are pending; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
req  input  4  request lines; bit0=a, bit1=b, bit2=c, bit3=d
a  input  WIDTH  source 0 data
b  input  WIDTH  source 1 data
c  input  WIDTH  source 2 data
d  input  WIDTH  source 3 data
grant  output  4  registered one-hot grant; all zero when idle
s1  output  1  select MSB (registered owner index bit1)
s0  output  1  select LSB (registered owner index bit0)
y  output  WIDTH  selected data gated by valid
valid  output  1  high when grant is non-zero

Behaviour:
- Single clock domain.
- rst is asynchronous and active-high. It forces: state=IDLE, grant=0000, {s1,s0}=00, valid=0, y=0, ptr=0, cnt=0.
- ptr (2 bits) is the highest-priority index for the next arbitration. The search order is ptr, ptr+1, ... modulo 4.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the next edge, grant the first requester in search order. Go to GRANT with cnt=0 and {s1,s0}=winner index.
  - Request-to-grant latency is 1 cycle.
- GRANT, with owner idx:
  - On each edge, evaluate the release conditions:
    - R1: req[idx]==0.
    - R2: cnt==MAX_BURST-1 and (req & ~onehot(idx))!=0.
  - On release:
    - ptr <= idx+1 mod 4.
    - Pick the next winner from the current req, excluding idx, searching from idx+1.
    - If a winner exists, the new owner takes the grant at the same edge with no idle bubble, and cnt is reset to 0.
    - If no winner exists, go to IDLE and set grant=0000.
  - No release: keep the owner and set cnt <= cnt+1.
  - cnt saturates at MAX_BURST-1 while the owner is alone, so the owner holds indefinitely.
- {s1,s0} holds the last owner index while IDLE.
- Output path:
  - y = valid ? mux(a,b,c,d by {s1,s0}) : 0. This is combinational from the registered select.
  - valid = |grant.
- grant is always one-hot or zero. A 2+-hot grant is an error and must be covered by a bench assertion.
- MAX_BURST=1: the owner rotates every cycle whenever any other request is pending.
- Boundary cases:
  - Request dropped and raised in the same cycle by different sources: the new requester is considered at that edge.
  - Reset asserted mid-burst: outputs clear immediately, without waiting for a clock. After release, arbitration restarts from ptr=0.

Test Plan:
- Reset/idle: assert rst, then release with req=0000 -> grant=0000, valid=0, y=0, {s1,s0}=00 for 10 cycles.
- Single requester: req=0100, c=1 -> one cycle later grant=0100, {s1,s0}=10, y=1, valid=1. The grant holds past 4 cycles. Dropping req gives grant=0000 on the next edge.
- Round-robin fairness: req=1111 held, a=0 b=1 c=0 d=1, MAX_BURST=4 -> the grant sequence is 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles. y follows 0,1,0,1.
- Early release handover: owner b with req=0011; drop req[1] at cycle 2 of the burst -> the next edge grants 0001 with no idle cycle, and cnt restarts.
- Priority pointer: after b releases (ptr=2), assert req=1001 -> d is granted before a.
- Async reset mid-burst: assert rst between clock edges while grant=0100 -> grant=0000 and valid=0 before the next edge. After release with req=1111, the first grant is 0001.
